serial_mul_sequencer: RTL and testbench

Sequencer sitting at the other end of the PE bit-serial signed multiplier's control interface. It accepts operand pairs over a valid/ready handshake and drives the multiplier's operand strobe, bit index and result-window strobe. It then captures the 2*BITWIDTH-bit product and returns it over a valid/ready result handshake. One multiplication is in flight at a time; a one-entry result buffer decouples downstream backpressure.

---
 rtl/serial_mul_sequencer_pkg.sv | 26 ++
 rtl/serial_mul_sequencer_result_buf.sv | 45 ++++
 rtl/serial_mul_sequencer.sv | 151 +++++++++++++++
 tb/tb_serial_mul_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_mul_sequencer_pkg.sv
// rtl/serial_mul_sequencer_pkg.sv - shared constants, state encoding and helpers for the serial multiplier sequencer
package serial_mul_sequencer_pkg;

   localparam int DEFAULT_BITWIDTH = 8;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   localparam int LC_W = clog2(DEFAULT_BITWIDTH) + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

endpackage

// File: rtl/serial_mul_sequencer_result_buf.sv
// rtl/serial_mul_sequencer_result_buf.sv - one-entry valid/ready result holding register
module serial_result_buf #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         full,
   output logic         drain
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign full      = valid_q;
   assign drain     = valid_q && out_ready;

endmodule

// File: rtl/serial_mul_sequencer.sv
// rtl/serial_mul_sequencer.sv - operand/handshake sequencer driving a bit-serial signed multiplier
module serial_mul_sequencer
   import serial_mul_sequencer_pkg::*;
#(
   parameter  int BITWIDTH = DEFAULT_BITWIDTH,
   parameter  int WDOG     = 4,
   localparam int LCW      = clog2(BITWIDTH) + 2,
   localparam int PW       = 2 * BITWIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] in_a,
   input  logic [BITWIDTH-1:0] in_b,
   input  logic                in_weight_int,
   output logic                mul_data_in_valid,
   output logic [BITWIDTH-1:0] mul_a,
   output logic [BITWIDTH-1:0] mul_b,
   output logic                mul_weight_int,
   output logic [LCW-1:0]      last_count,
   output logic                metronome_data_out_valid,
   input  logic                mul_data_out_valid,
   input  logic [PW-1:0]       mul_dout,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PW-1:0]       out_data,
   output logic                err
);

   localparam int             WDW     = clog2(WDOG) + 1;
   localparam logic [LCW-1:0] LC_LAST = LCW'(BITWIDTH - 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG - 1);

   state_e              state_q, state_d;
   logic [BITWIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic                mul_wi_q, mul_wi_d;
   logic                mdiv_q, mdiv_d, met_q, met_d;
   logic [LCW-1:0]      lc_q, lc_d;
   logic [WDW-1:0]      wd_q, wd_d;
   logic                err_q, err_d;
   logic [PW-1:0]       cap_q, cap_d;
   logic                cap_valid_q, cap_valid_d;
   logic                buf_full, buf_drain, buf_load;

   // A captured product waits here until the buffer frees; in_ready keeps it from ever being overwritten.
   assign buf_load = cap_valid_q && (!buf_full || buf_drain);
   assign in_ready = (state_q == ST_IDLE) && (!buf_full || buf_drain);

   always_comb begin
      state_d     = state_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_wi_d    = mul_wi_q;
      mdiv_d      = 1'b0;
      met_d       = 1'b0;
      lc_d        = lc_q;
      wd_d        = wd_q;
      err_d       = err_q;
      cap_d       = cap_q;
      cap_valid_d = buf_load ? 1'b0 : cap_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               mul_a_d  = in_a;
               mul_b_d  = in_b;
               mul_wi_d = in_weight_int;
               mdiv_d   = 1'b1;
               lc_d     = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            lc_d    = '0;
            wd_d    = '0;
            met_d   = (LC_LAST == '0);
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (lc_q == LC_LAST) begin
               state_d = ST_WAIT;
            end else begin
               lc_d  = lc_q + LCW'(1);
               met_d = ((lc_q + LCW'(1)) == LC_LAST);
            end
         end
         ST_WAIT: begin
            if (mul_data_out_valid) begin
               cap_d       = mul_dout;
               cap_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_wi_q    <= 1'b0;
         mdiv_q      <= 1'b0;
         met_q       <= 1'b0;
         lc_q        <= '0;
         wd_q        <= '0;
         err_q       <= 1'b0;
         cap_q       <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_wi_q    <= mul_wi_d;
         mdiv_q      <= mdiv_d;
         met_q       <= met_d;
         lc_q        <= lc_d;
         wd_q        <= wd_d;
         err_q       <= err_d;
         cap_q       <= cap_d;
         cap_valid_q <= cap_valid_d;
      end
   end

   serial_result_buf #(.W(PW)) u_result_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .load_data (cap_q),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .full      (buf_full),
      .drain     (buf_drain)
   );

   assign mul_data_in_valid        = mdiv_q;
   assign mul_a                    = mul_a_q;
   assign mul_b                    = mul_b_q;
   assign mul_weight_int           = mul_wi_q;
   assign last_count               = lc_q;
   assign metronome_data_out_valid = met_q;
   assign err                      = err_q;

endmodule

// File: tb/tb_serial_mul_sequencer.sv
// tb/tb_serial_mul_sequencer.sv - scoreboard bench for serial_mul_sequencer with a stub multiplier
module tb_serial_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_weight_int = 1'b0;
   logic        mul_data_in_valid;
   logic [7:0]  mul_a, mul_b;
   logic        mul_weight_int;
   logic [4:0]  last_count;
   logic        metronome_data_out_valid;
   logic        mul_data_out_valid;
   logic [15:0] mul_dout;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        err;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        stub_en = 1'b1;
   logic [15:0] exp_q[$];

   serial_mul_sequencer #(.BITWIDTH(8), .WDOG(4)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .in_valid                 (in_valid),
      .in_ready                 (in_ready),
      .in_a                     (in_a),
      .in_b                     (in_b),
      .in_weight_int            (in_weight_int),
      .mul_data_in_valid        (mul_data_in_valid),
      .mul_a                    (mul_a),
      .mul_b                    (mul_b),
      .mul_weight_int           (mul_weight_int),
      .last_count               (last_count),
      .metronome_data_out_valid (metronome_data_out_valid),
      .mul_data_out_valid       (mul_data_out_valid),
      .mul_dout                 (mul_dout),
      .out_valid                (out_valid),
      .out_ready                (out_ready),
      .out_data                 (out_data),
      .err                      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // stub multiplier: latches operands on load, answers one cycle after the metronome pulse
   logic signed [7:0]  sa, sb;
   logic               swi;
   logic signed [15:0] sprod;
   assign sprod = sa * sb;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sa <= '0; sb <= '0; swi <= 1'b0;
         mul_data_out_valid <= 1'b0;
         mul_dout <= '0;
      end else begin
         if (mul_data_in_valid) begin
            sa <= mul_a; sb <= mul_b; swi <= mul_weight_int;
         end
         mul_data_out_valid <= stub_en && metronome_data_out_valid;
         mul_dout <= swi ? {sa, 8'h00} : sprod;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at cycle %0d", nm, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result got=%h want=none at cycle %0d", out_data, cyc);
         end else begin
            chk("result", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic wi,
                       input logic push, input logic [15:0] e, output int acc);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      in_a = a; in_b = b; in_weight_int = wi; in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 1'b0;
      if (push) exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic drain_wait();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int a0, a1, a2, a3;
      int pulses;

      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outs", {out_valid, err, mul_data_in_valid, metronome_data_out_valid, last_count, out_data},
          32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // basic product, latency and serial sequencing
      send(8'd3, 8'd5, 1'b0, 1'b1, 16'h000F, a0);
      chk("load_strobe", 32'(mul_data_in_valid), 32'd1);
      chk("load_lc", 32'(last_count), 32'd0);
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k <= 8) chk($sformatf("lc_%0d", k), 32'(last_count), 32'(k - 1));
         if (k == 9) chk("lc_hold", 32'(last_count), 32'd7);
         if (metronome_data_out_valid) pulses++;
         if (k == 8) chk("met_last", 32'(metronome_data_out_valid), 32'd1);
      end
      chk("met_pulses", 32'(pulses), 32'd1);
      chk("early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency", {out_valid, 15'd0, 16'(cyc - a0)}, {1'b1, 15'd0, 16'd11});

      // signed products, bypass flag and back-to-back throughput
      send(8'hFD, 8'h05, 1'b0, 1'b1, 16'hFFF1, a1);
      send(8'h80, 8'h80, 1'b0, 1'b1, 16'h4000, a2);
      chk("throughput1", 32'(a2 - a1), 32'd11);
      send(8'h12, 8'h7F, 1'b1, 1'b1, 16'h1200, a3);
      chk("throughput2", 32'(a3 - a2), 32'd11);
      drain_wait();

      // backpressure: result held, new work blocked, accepted as soon as the drain happens
      out_ready = 1'b0;
      send(8'd7, 8'd9, 1'b0, 1'b1, 16'h003F, a0);
      for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
      in_a = 8'hFF; in_b = 8'h02; in_weight_int = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("stall_hold", {15'd0, out_valid, out_data, in_ready}, {15'd0, 1'b1, 16'h003F, 1'b0});
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("ready_on_drain", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back(16'hFFFE);
      @(negedge clk);
      chk("second_loaded", {mul_data_in_valid, mul_a, mul_b}, {1'b1, 8'hFF, 8'h02});
      drain_wait();

      // watchdog: multiplier never answers
      stub_en = 1'b0;
      send(8'd1, 8'd1, 1'b0, 1'b0, 16'h0000, a0);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 12) chk("err_before", 32'(err), 32'd0);
      end
      chk("err_set", 32'(err), 32'd1);
      chk("wdog_idle", 32'(in_ready), 32'd1);
      repeat (5) @(negedge clk);
      chk("wdog_no_result", 32'(out_valid), 32'd0);
      chk("err_sticky", 32'(err), 32'd1);
      stub_en = 1'b1;

      // asynchronous reset mid-run, then a clean operation
      send(8'd4, 8'd6, 1'b0, 1'b0, 16'h0000, a0);
      repeat (5) @(negedge clk);
      chk("pre_rst_lc", 32'(last_count), 32'd4);
      rst = 1'b1;
      #1;
      chk("async_rst_outs", {out_valid, err, mul_data_in_valid, metronome_data_out_valid, last_count, mul_a, mul_b},
          32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(8'h0B, 8'hF6, 1'b0, 1'b1, 16'hFF92, a0);
      drain_wait();
      chk("final_err_clear", 32'(err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
